// File: rtl/sprite_motion_ctrl_if.sv
// Candidate-position handshake between the sprite controller and the external maze/collision checker.
interface sprite_motion_ctrl_if #(
  parameter int unsigned COORD_W = 10
);
  logic               cand_valid;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_ack;
  logic               cand_ok;

  modport master (output cand_valid, cand_x, cand_y, input cand_ack, cand_ok);
  modport slave  (input cand_valid, cand_x, cand_y, output cand_ack, cand_ok);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite mover: decodes HID keycodes on each VGA frame tick, clamps the step to the
// screen, and gets every move approved by an external checker with diagonal -> X -> Y fallback.
module sprite_motion_ctrl #(
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned COORD_W     = 10,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          Y_MIN       = 0,
  parameter int          Y_MAX       = 479,
  parameter int          X_START     = 320,
  parameter int          Y_START     = 240,
  parameter int          SIZE        = 4,
  parameter int          STEP        = 1,
  parameter logic [7:0]  K_UP        = 8'h1A,
  parameter logic [7:0]  K_LEFT      = 8'h04,
  parameter logic [7:0]  K_DOWN      = 8'h16,
  parameter logic [7:0]  K_RIGHT     = 8'h07,
  parameter logic [7:0]  K_HOME      = 8'h15,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_vs,
  input  logic [8*NUM_KEYS-1:0] keycode,
  sprite_motion_ctrl_if.master  cand,
  output logic [COORD_W-1:0]    pos_x,
  output logic [COORD_W-1:0]    pos_y,
  output logic [COORD_W-1:0]    pos_s,
  output logic [15:0]           frame_cnt,
  output logic                  overrun
);
  localparam int          X_LO  = X_MIN + SIZE;
  localparam int          X_HI  = X_MAX - SIZE;
  localparam int          Y_LO  = Y_MIN + SIZE;
  localparam int          Y_HI  = Y_MAX - SIZE;
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef logic signed [COORD_W:0] sc_t;
  typedef enum logic [1:0] {IDLE, EVAL, REQ, COMMIT} state_t;
  typedef enum logic [1:0] {ATT_FULL, ATT_X_ONLY, ATT_Y_ONLY} attempt_t;

  function automatic logic [COORD_W-1:0] step_clamp(input logic [COORD_W-1:0] p,
                                                    input logic dec, input logic inc,
                                                    input sc_t lo, input sc_t hi);
    sc_t v;
    v = sc_t'({1'b0, p});
    if (inc && !dec)      v = v + sc_t'(STEP);
    else if (dec && !inc) v = v - sc_t'(STEP);
    if (v < lo)      v = lo;
    else if (v > hi) v = hi;
    return v[COORD_W-1:0];
  endfunction

  state_t             state_q, state_d;
  attempt_t           attempt_q, attempt_d;
  logic [2:0]         vs_q;
  logic               tick_q;
  logic               both_q, both_d;
  logic               cand_valid_q, cand_valid_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d, ty_q, ty_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;
  logic               k_up, k_dn, k_lf, k_rt, k_home;
  logic [COORD_W-1:0] ex, ey;

  always_comb begin
    k_up = 1'b0; k_dn = 1'b0; k_lf = 1'b0; k_rt = 1'b0; k_home = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keycode[8*i +: 8] == K_UP)    k_up   = 1'b1;
      if (keycode[8*i +: 8] == K_DOWN)  k_dn   = 1'b1;
      if (keycode[8*i +: 8] == K_LEFT)  k_lf   = 1'b1;
      if (keycode[8*i +: 8] == K_RIGHT) k_rt   = 1'b1;
      if (keycode[8*i +: 8] == K_HOME)  k_home = 1'b1;
    end
  end

  assign ex = step_clamp(pos_x_q, lf_q, rt_q, sc_t'(X_LO), sc_t'(X_HI));
  assign ey = step_clamp(pos_y_q, up_q, dn_q, sc_t'(Y_LO), sc_t'(Y_HI));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= {vs_q[1:0], frame_vs};
      tick_q <= vs_q[1] & ~vs_q[2];
    end
  end

  always_comb begin
    state_d      = state_q;
    attempt_d    = attempt_q;
    both_d       = both_q;
    cand_valid_d = cand_valid_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    ty_d         = ty_q;
    tmo_d        = tmo_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    up_d = up_q; dn_d = dn_q; lf_d = lf_q; rt_d = rt_q;
    frame_cnt_d  = frame_cnt_q + {15'd0, tick_q};
    overrun_d    = overrun_q | (tick_q & (state_q != IDLE));
    case (state_q)
      IDLE: if (tick_q) begin
        up_d = k_up; dn_d = k_dn; lf_d = k_lf; rt_d = k_rt;
        if (k_home) begin
          cand_x_d = COORD_W'(X_START);
          cand_y_d = COORD_W'(Y_START);
          state_d  = COMMIT;
        end else begin
          state_d  = EVAL;
        end
      end
      // Axis "moves" are judged after clamping, so a blocked axis makes the move single-axis.
      EVAL: begin
        if (ex == pos_x_q && ey == pos_y_q) begin
          state_d = IDLE;
        end else begin
          cand_x_d     = ex;
          cand_y_d     = ey;
          ty_d         = ey;
          both_d       = (ex != pos_x_q) && (ey != pos_y_q);
          attempt_d    = ATT_FULL;
          tmo_d        = '0;
          cand_valid_d = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (!cand_valid_q) begin
          cand_valid_d = 1'b1;
        end else if (cand.cand_ack && cand.cand_ok) begin
          cand_valid_d = 1'b0;
          state_d      = COMMIT;
        end else if (cand.cand_ack || tmo_q == TMO_LAST) begin
          cand_valid_d = 1'b0;
          tmo_d        = '0;
          if (attempt_q == ATT_FULL && both_q) begin
            attempt_d = ATT_X_ONLY;
            cand_y_d  = pos_y_q;
          end else if (attempt_q == ATT_X_ONLY) begin
            attempt_d = ATT_Y_ONLY;
            cand_x_d  = pos_x_q;
            cand_y_d  = ty_q;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      COMMIT: begin
        pos_x_d = cand_x_q;
        pos_y_d = cand_y_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      attempt_q    <= ATT_FULL;
      both_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_x_q     <= COORD_W'(X_START);
      cand_y_q     <= COORD_W'(Y_START);
      ty_q         <= COORD_W'(Y_START);
      tmo_q        <= '0;
      pos_x_q      <= COORD_W'(X_START);
      pos_y_q      <= COORD_W'(Y_START);
      up_q <= 1'b0; dn_q <= 1'b0; lf_q <= 1'b0; rt_q <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      attempt_q    <= attempt_d;
      both_q       <= both_d;
      cand_valid_q <= cand_valid_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      ty_q         <= ty_d;
      tmo_q        <= tmo_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      up_q <= up_d; dn_q <= dn_d; lf_q <= lf_d; rt_q <= rt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cand.cand_valid = cand_valid_q;
  assign cand.cand_x     = cand_x_q;
  assign cand.cand_y     = cand_y_q;
  assign pos_x           = pos_x_q;
  assign pos_y           = pos_y_q;
  assign pos_s           = COORD_W'(SIZE);
  assign frame_cnt       = frame_cnt_q;
  assign overrun         = overrun_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: a behavioural frame model plus an emulated collision checker.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;
  localparam int CW = 10;
  localparam int XS = 320, YS = 240, XLO = 4, XHI = 635, YLO = 4, YHI = 475;
  localparam int M_ACCEPT = 0, M_REJ_DIAG = 1, M_NOACK = 2, M_RAND = 3;

  logic          Clk = 1'b0, Reset_n = 1'b0, frame_vs = 1'b0;
  logic [15:0]   keycode = '0;
  logic [CW-1:0] pos_x, pos_y, pos_s;
  logic [15:0]   frame_cnt;
  logic          overrun;

  sprite_motion_ctrl_if #(.COORD_W(CW)) cif ();

  sprite_motion_ctrl #(.NUM_KEYS(2), .COORD_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .keycode(keycode), .cand(cif),
    .pos_x(pos_x), .pos_y(pos_y), .pos_s(pos_s), .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;
  int mx = XS, my = YS, mcnt = 0;
  int e_rx[$], e_ry[$];
  int lat;
  int chk_mode = M_ACCEPT, chk_dly_max = 0;
  int req_x[$], req_y[$];
  bit req_ok[$];
  int vcycles = 0, cyc = 0, first_v = -1, last_v = -1;

  // Emulated checker: logs each request, decides it, acks after a (possibly random) delay.
  initial begin
    int  wait_cnt;
    bit  cur_ok;
    cif.cand_ack = 1'b0;
    cif.cand_ok  = 1'b0;
    wait_cnt = -1;
    cur_ok   = 1'b0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!cif.cand_valid) begin
        cif.cand_ack = 1'b0; cif.cand_ok = 1'b0; wait_cnt = -1;
      end else begin
        vcycles++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (wait_cnt < 0) begin
          req_x.push_back(int'(cif.cand_x));
          req_y.push_back(int'(cif.cand_y));
          case (chk_mode)
            M_ACCEPT:   cur_ok = 1'b1;
            M_REJ_DIAG: cur_ok = !(int'(cif.cand_x) != mx && int'(cif.cand_y) != my);
            M_NOACK:    cur_ok = 1'b0;
            default:    cur_ok = bit'($urandom_range(0, 1));
          endcase
          req_ok.push_back(cur_ok);
          wait_cnt = (chk_dly_max > 0) ? int'($urandom_range(0, chk_dly_max)) : 0;
        end
        if (chk_mode != M_NOACK && wait_cnt == 0) begin
          cif.cand_ack = 1'b1; cif.cand_ok = cur_ok;
        end else begin
          cif.cand_ack = 1'b0; cif.cand_ok = 1'b0;
          if (wait_cnt > 0) wait_cnt--;
        end
      end
    end
  end

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic do_reset();
    Reset_n = 1'b0; frame_vs = 1'b0; keycode = '0;
    chk_mode = M_ACCEPT; chk_dly_max = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    mx = XS; my = YS; mcnt = 0;
  endtask

  // Drives one frame pulse (plus an optional second pulse at extra_at) and advances the model.
  task automatic run_frame(input logic [15:0] kc, input int settle, input bit scramble, input int extra_at);
    bit up, dn, lf, rt, hm, done;
    int tx, ty, ax[$], ay[$];
    logic [7:0] k;
    up = 0; dn = 0; lf = 0; rt = 0; hm = 0;
    for (int i = 0; i < 2; i++) begin
      k = kc[8*i +: 8];
      if (k == 8'h1A) up = 1;
      if (k == 8'h16) dn = 1;
      if (k == 8'h04) lf = 1;
      if (k == 8'h07) rt = 1;
      if (k == 8'h15) hm = 1;
    end
    req_x.delete(); req_y.delete(); req_ok.delete();
    vcycles = 0; first_v = -1; last_v = -1;
    keycode = kc;
    @(negedge Clk) frame_vs = 1'b1;
    lat = -1;
    for (int c = 1; c <= settle; c++) begin
      @(posedge Clk); #1;
      if (c == 4) frame_vs = 1'b0;
      if (extra_at > 0 && c == extra_at) frame_vs = 1'b1;
      if (extra_at > 0 && c == extra_at + 4) frame_vs = 1'b0;
      if (scramble && c == 5) keycode = 16'($urandom);
      if (lat < 0 && (int'(pos_x) != mx || int'(pos_y) != my)) lat = c;
    end
    mcnt += (extra_at > 0) ? 2 : 1;
    e_rx.delete(); e_ry.delete();
    if (hm) begin
      mx = XS; my = YS;
    end else begin
      tx = clampi(mx + ((rt && !lf) ? 1 : 0) - ((lf && !rt) ? 1 : 0), XLO, XHI);
      ty = clampi(my + ((dn && !up) ? 1 : 0) - ((up && !dn) ? 1 : 0), YLO, YHI);
      if (tx != mx || ty != my) begin
        ax.push_back(tx); ay.push_back(ty);
        if (tx != mx && ty != my) begin
          ax.push_back(tx); ay.push_back(my);
          ax.push_back(mx); ay.push_back(ty);
        end
      end
      done = 0;
      for (int i = 0; i < ax.size() && !done; i++) begin
        e_rx.push_back(ax[i]); e_ry.push_back(ay[i]);
        if (i < req_ok.size() && req_ok[i]) begin
          mx = ax[i]; my = ay[i]; done = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (pos_x !== 10'd320) begin n_err++; $display("FAIL reset_pos_x: got %0d expected 320", pos_x); end
    n_vec++; if (pos_y !== 10'd240) begin n_err++; $display("FAIL reset_pos_y: got %0d expected 240", pos_y); end
    n_vec++; if (pos_s !== 10'd4) begin n_err++; $display("FAIL reset_pos_s: got %0d expected 4", pos_s); end
    n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_vec++; if (cif.cand_valid !== 1'b0) begin n_err++; $display("FAIL reset_cand_valid: got %b expected 0", cif.cand_valid); end
    n_vec++; if (cif.cand_x !== 10'd320 || cif.cand_y !== 10'd240) begin
      n_err++; $display("FAIL reset_cand_xy: got (%0d,%0d) expected (320,240)", cif.cand_x, cif.cand_y); end
  endtask

  task automatic test_idle_frames();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(16'h0000, 12, 0, 0);
      n_vec++; if (req_x.size() != 0) begin n_err++; $display("FAIL idle_no_request: got %0d requests expected 0", req_x.size()); end
    end
    n_vec++; if (pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL idle_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y); end
    n_vec++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL idle_frame_cnt: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_right_run();
    do_reset();
    for (int f = 0; f < 10; f++) begin
      run_frame(16'h0007, 12, 0, 0);
      n_vec++; if (lat != 7) begin n_err++; $display("FAIL right_latency: got %0d cycles expected 7 (vs->pos)", lat); end
      n_vec++; if (int'(pos_x) != mx || int'(pos_y) != my) begin
        n_err++; $display("FAIL right_pos: got (%0d,%0d) expected (%0d,%0d)", pos_x, pos_y, mx, my); end
    end
    n_vec++; if (pos_x !== 10'd330 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL right_final: got (%0d,%0d) expected (330,240)", pos_x, pos_y); end
    n_vec++; if (frame_cnt !== 16'd10) begin n_err++; $display("FAIL right_frame_cnt: got %0d expected 10", frame_cnt); end
  endtask

  task automatic test_diag_fallback();
    do_reset();
    chk_mode = M_REJ_DIAG;
    run_frame(16'h071A, 16, 0, 0);
    n_vec++; if (req_x.size() != 2) begin n_err++; $display("FAIL diag_req_count: got %0d expected 2", req_x.size()); end
    n_vec++; if (req_x.size() >= 2 && (req_x[0] != 321 || req_y[0] != 239 || req_x[1] != 321 || req_y[1] != 240)) begin
      n_err++; $display("FAIL diag_req_seq: got (%0d,%0d),(%0d,%0d) expected (321,239),(321,240)",
                        req_x[0], req_y[0], req_x[1], req_y[1]); end
    n_vec++; if (pos_x !== 10'd321 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL diag_pos: got (%0d,%0d) expected (321,240)", pos_x, pos_y); end
  endtask

  task automatic test_bounds();
    do_reset();
    for (int f = 0; f < 315; f++) begin
      run_frame(16'h0007, 10, 0, 0);
      n_vec++; if (int'(pos_x) != mx) begin n_err++; $display("FAIL bound_walk: frame %0d got %0d expected %0d", f, pos_x, mx); end
    end
    n_vec++; if (pos_x !== 10'd635) begin n_err++; $display("FAIL bound_reach: got %0d expected 635", pos_x); end
    run_frame(16'h0007, 12, 0, 0);
    n_vec++; if (req_x.size() != 0) begin n_err++; $display("FAIL bound_no_request: got %0d expected 0", req_x.size()); end
    n_vec++; if (pos_x !== 10'd635) begin n_err++; $display("FAIL bound_hold: got %0d expected 635", pos_x); end
    run_frame(16'h0704, 12, 0, 0);
    n_vec++; if (req_x.size() != 0) begin n_err++; $display("FAIL lr_cancel_request: got %0d expected 0", req_x.size()); end
    n_vec++; if (pos_x !== 10'd635 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL lr_cancel_pos: got (%0d,%0d) expected (635,240)", pos_x, pos_y); end
  endtask

  task automatic test_timeout_overrun();
    do_reset();
    chk_mode = M_NOACK;
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL tmo_overrun_pre: got %b expected 0", overrun); end
    run_frame(16'h071A, 800, 0, 100);
    n_vec++; if (req_x.size() != 3) begin n_err++; $display("FAIL tmo_attempts: got %0d expected 3", req_x.size()); end
    for (int i = 0; i < 3 && i < req_x.size(); i++) begin
      n_vec++; if (req_x[i] != e_rx[i] || req_y[i] != e_ry[i]) begin
        n_err++; $display("FAIL tmo_req_%0d: got (%0d,%0d) expected (%0d,%0d)", i, req_x[i], req_y[i], e_rx[i], e_ry[i]); end
    end
    n_vec++; if (vcycles != 765) begin n_err++; $display("FAIL tmo_valid_cycles: got %0d expected 765", vcycles); end
    n_vec++; if (last_v - first_v + 1 != 767) begin
      n_err++; $display("FAIL tmo_span: got %0d expected 767", last_v - first_v + 1); end
    n_vec++; if (pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL tmo_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL tmo_overrun: got %b expected 1", overrun); end
    n_vec++; if (int'(frame_cnt) != mcnt) begin n_err++; $display("FAIL tmo_frame_cnt: got %0d expected %0d", frame_cnt, mcnt); end
  endtask

  task automatic test_home_and_reset();
    bit seen;
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(16'h0016, 12, 0, 0);
    n_vec++; if (pos_y !== 10'd243) begin n_err++; $display("FAIL home_pre: got %0d expected 243", pos_y); end
    run_frame(16'h1500, 12, 0, 0);
    n_vec++; if (req_x.size() != 0) begin n_err++; $display("FAIL home_no_request: got %0d expected 0", req_x.size()); end
    n_vec++; if (pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL home_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y); end
    chk_mode = M_NOACK;
    keycode = 16'h0007;
    @(negedge Clk) frame_vs = 1'b1;
    seen = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge Clk); #1;
      if (c == 4) frame_vs = 1'b0;
      if (cif.cand_valid === 1'b1) seen = 1;
    end
    frame_vs = 1'b0;
    n_vec++; if (!seen) begin n_err++; $display("FAIL rst_req_seen: got no request within 20 cycles expected one"); end
    #2 Reset_n = 1'b0;
    #1;
    n_vec++; if (cif.cand_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b expected 0", cif.cand_valid); end
    n_vec++; if (frame_cnt !== 16'd0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL rst_async_regs: got cnt=%0d ovr=%b expected cnt=0 ovr=0", frame_cnt, overrun); end
    n_vec++; if (pos_x !== 10'd320 || pos_y !== 10'd240) begin
      n_err++; $display("FAIL rst_async_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y); end
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    mx = XS; my = YS; mcnt = 0; chk_mode = M_ACCEPT;
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 3)  return 8'h00;
    if (r < 5)  return 8'h1A;
    if (r < 7)  return 8'h04;
    if (r < 9)  return 8'h16;
    if (r < 11) return 8'h07;
    if (r < 12) return 8'h15;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic test_random();
    bit bad;
    do_reset();
    chk_mode = M_RAND; chk_dly_max = 3;
    for (int f = 0; f < 40; f++) begin
      run_frame({rand_key(), rand_key()}, 30, 1, 0);
      bad = (req_x.size() != e_rx.size());
      for (int i = 0; i < req_x.size() && i < e_rx.size(); i++)
        if (req_x[i] != e_rx[i] || req_y[i] != e_ry[i]) bad = 1;
      n_vec++; if (bad) begin
        n_err++; $display("FAIL rand_reqs: frame %0d got %0d requests expected %0d (or coords differ)", f, req_x.size(), e_rx.size()); end
      n_vec++; if (int'(pos_x) != mx || int'(pos_y) != my) begin
        n_err++; $display("FAIL rand_pos: frame %0d got (%0d,%0d) expected (%0d,%0d)", f, pos_x, pos_y, mx, my); end
      n_vec++; if (int'(frame_cnt) != mcnt) begin
        n_err++; $display("FAIL rand_frame_cnt: frame %0d got %0d expected %0d", f, frame_cnt, mcnt); end
    end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_right_run();
    test_diag_fallback();
    test_bounds();
    test_timeout_overrun();
    test_home_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
